// File: rtl/kernel_bank_if.sv
// Bundle of read-port, tap-stream, write-port and tap-sum signals for kernel_bank.
// master = the surrounding datapath/controller, slave = the kernel bank itself.
interface kernel_bank_if #(
    parameter int COEF_W = 5,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 2,
    parameter int SUM_W  = COEF_W + 4
);
    logic        [SEL_W-1:0]  sel;
    logic        [ADDR_W-1:0] rd_addr;
    logic signed [COEF_W-1:0] rd_dout;
    logic                     start;
    logic                     busy;
    logic                     st_valid;
    logic                     st_ready;
    logic signed [COEF_W-1:0] st_data;
    logic        [ADDR_W-1:0] st_idx;
    logic                     st_last;
    logic                     wr_en;
    logic        [SEL_W-1:0]  wr_kernel;
    logic        [ADDR_W-1:0] wr_addr;
    logic signed [COEF_W-1:0] wr_data;
    logic                     wr_err;
    logic signed [SUM_W-1:0]  ker_sum;

    modport master (
        output sel, rd_addr, start, st_ready, wr_en, wr_kernel, wr_addr, wr_data,
        input  rd_dout, busy, st_valid, st_data, st_idx, st_last, wr_err, ker_sum
    );

    modport slave (
        input  sel, rd_addr, start, st_ready, wr_en, wr_kernel, wr_addr, wr_data,
        output rd_dout, busy, st_valid, st_data, st_idx, st_last, wr_err, ker_sum
    );
endinterface

// File: rtl/kernel_bank.sv
// Writable bank of NKER signed KSIZE x KSIZE convolution kernels with a registered
// random-access read port, a valid/ready tap stream and a registered tap-sum output.
module kernel_bank #(
    parameter int COEF_W = 5,
    parameter int KSIZE  = 3,
    parameter int NKER   = 4,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 2,
    parameter int SUM_W  = COEF_W + 4
) (
    input  logic          clk,
    input  logic          rst,
    kernel_bank_if.slave  bus
);
    localparam int                N        = KSIZE * KSIZE;
    localparam int                CENTRE   = (KSIZE / 2) * KSIZE + (KSIZE / 2);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    // Preset contents: blur / edge / sharpen in slots 0..2 for 3x3, identity elsewhere.
    function automatic logic signed [COEF_W-1:0] preset_tap(input int k, input int t);
        int v;
        v = (t == CENTRE) ? 1 : 0;
        if (KSIZE == 3) begin
            case (k)
                0:       v = (t == 4) ? 8  : 3;
                1:       v = (t == 4) ? -4 : ((t % 2 == 1) ? 1 : 0);
                2:       v = (t == 4) ? 5  : ((t % 2 == 1) ? -1 : 0);
                default: ;
            endcase
        end
        return COEF_W'(v);
    endfunction

    logic signed [COEF_W-1:0] r_mem [NKER][N];
    state_t                   r_state;
    logic        [SEL_W-1:0]  r_skern;
    logic        [ADDR_W-1:0] r_idx;
    logic                     r_busy;
    logic                     r_st_valid;
    logic signed [COEF_W-1:0] r_st_data;
    logic                     r_st_last;
    logic signed [COEF_W-1:0] r_rd_dout;
    logic                     r_wr_err;
    logic signed [SUM_W-1:0]  r_ker_sum;

    logic                     w_sel_ok;
    logic                     w_rd_ok;
    logic                     w_wr_ok;
    logic signed [COEF_W-1:0] w_rd_val;
    logic signed [SUM_W-1:0]  w_sum;
    logic        [ADDR_W-1:0] w_idx_nxt;

    assign w_sel_ok  = 32'(bus.sel) < NKER;
    assign w_rd_ok   = w_sel_ok && (32'(bus.rd_addr) < N);
    assign w_wr_ok   = bus.wr_en
                    && (32'(bus.wr_addr) < N)
                    && (32'(bus.wr_kernel) < NKER)
                    && !(r_busy && (bus.wr_kernel == r_skern));
    assign w_rd_val  = w_rd_ok ? r_mem[bus.sel][bus.rd_addr] : '0;
    assign w_idx_nxt = r_idx + ADDR_W'(1);

    always_comb begin
        w_sum = '0;
        if (w_sel_ok) begin
            for (int t = 0; t < N; t++) begin
                w_sum = w_sum + SUM_W'(r_mem[bus.sel][t]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the coefficient array is reset on purpose: it is a small register file
            // whose reset value is the preset kernel set, not a RAM macro.
            for (int k = 0; k < NKER; k++) begin
                for (int t = 0; t < N; t++) begin
                    r_mem[k][t] <= preset_tap(k, t);
                end
            end
            r_state    <= S_IDLE;
            r_skern    <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_st_valid <= 1'b0;
            r_st_data  <= '0;
            r_st_last  <= 1'b0;
            r_rd_dout  <= '0;
            r_wr_err   <= 1'b0;
            r_ker_sum  <= '0;
        end else begin
            // NOTE: non-blocking updates make every read in this edge see the array as it
            // stood before the write, which is what gives read-before-write on a shared tap.
            if (w_wr_ok) begin
                r_mem[bus.wr_kernel][bus.wr_addr] <= bus.wr_data;
            end
            r_wr_err  <= bus.wr_en && !w_wr_ok;
            r_rd_dout <= w_rd_val;
            r_ker_sum <= w_sum;

            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_sel_ok) begin
                        r_state    <= S_STREAM;
                        r_skern    <= bus.sel;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_st_valid <= 1'b1;
                        r_st_data  <= r_mem[bus.sel][0];
                        r_st_last  <= (N == 1);
                    end
                end
                S_STREAM: begin
                    // Data stays put while stalled because writes to r_skern are rejected.
                    if (bus.st_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= S_IDLE;
                            r_idx      <= '0;
                            r_busy     <= 1'b0;
                            r_st_valid <= 1'b0;
                            r_st_data  <= '0;
                            r_st_last  <= 1'b0;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_st_data <= r_mem[r_skern][w_idx_nxt];
                            r_st_last <= (w_idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_dout  = r_rd_dout;
    assign bus.busy     = r_busy;
    assign bus.st_valid = r_st_valid;
    assign bus.st_data  = r_st_data;
    assign bus.st_idx   = r_idx;
    assign bus.st_last  = r_st_last;
    assign bus.wr_err   = r_wr_err;
    assign bus.ker_sum  = r_ker_sum;
endmodule
